// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
//
// The WIDTH-bit operation is cut into STAGES slices of SLICE = WIDTH/STAGES
// bits. Stage k ripples through bits [k*SLICE +: SLICE] using the carry
// registered by stage k-1. Operand bits not yet consumed are carried along
// (skewed) with the transaction. Finished low result slices accumulate stage
// by stage (de-skewed), so the whole of z leaves the last stage together.
//
// Parameters
//   WIDTH   operand/result width, must be a multiple of STAGES
//   STAGES  number of pipeline stages, 1..WIDTH
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset, clears control and data
//   in_valid   operand transaction present
//   in_ready   pipe can accept this cycle (= !out_valid || out_ready)
//   x, y       operands A and B
//   c_in       carry-in (add) / borrow-in (sub)
//   sub        0: x + y + c_in, 1: x - y - c_in
//   out_valid  result present
//   out_ready  downstream accepts result
//   z          result, mod 2^WIDTH
//   c_out      carry-out (add) / borrow-out (sub)
//   ovf        signed two's-complement overflow
// -----------------------------------------------------------------------------
module pipe_addsub #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             c_out,
   output logic             ovf
);

   localparam int SLICE = WIDTH / STAGES;

   // Whole pipe moves as one; a stalled result freezes every stage.
   logic en;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Chain of full-adder cells over one slice; returns {carry_out, sum}.
   function automatic logic [SLICE:0] ripple_add(
      input logic [SLICE-1:0] a,
      input logic [SLICE-1:0] b,
      input logic             cin
   );
      logic [SLICE:0] res;
      logic           c;
      c   = cin;
      res = '0;
      for (int i = 0; i < SLICE; i++) begin
         res[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      res[SLICE] = c;
      return res;
   endfunction

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Operand bits still to be summed when entering stage k.
      localparam int HI = WIDTH - k * SLICE;

      logic [HI-1:0]          a_src;
      logic [HI-1:0]          b_src;
      logic                   c_src;
      logic                   s_src;
      logic                   v_src;
      logic [SLICE:0]         sum_w;
      logic [(k+1)*SLICE-1:0] r_d;
      logic [(k+1)*SLICE-1:0] r_q;
      logic                   vld_q;

      if (k == 0) begin : g_src
         // Subtract folds into add: x + ~y + !c_in.
         assign a_src = x;
         assign b_src = sub ? ~y : y;
         assign c_src = c_in ^ sub;
         assign s_src = sub;
         assign v_src = in_valid;
         assign r_d   = sum_w[SLICE-1:0];
      end else begin : g_src
         assign a_src = g_stage[k-1].g_fwd.xo_q;
         assign b_src = g_stage[k-1].g_fwd.yo_q;
         assign c_src = g_stage[k-1].g_fwd.c_q;
         assign s_src = g_stage[k-1].g_fwd.s_q;
         assign v_src = g_stage[k-1].vld_q;
         assign r_d   = {sum_w[SLICE-1:0], g_stage[k-1].r_q};
      end

      assign sum_w = ripple_add(a_src[SLICE-1:0], b_src[SLICE-1:0], c_src);

      // ---- stage k register boundary ----
      // Data only loads under a real transaction, so bubbles never disturb
      // the held result.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            r_q   <= '0;
         end else if (en) begin
            vld_q <= v_src;
            if (v_src) begin
               r_q <= r_d;
            end
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [HI-SLICE-1:0] xo_q;
         logic [HI-SLICE-1:0] yo_q;
         logic                c_q;
         logic                s_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               xo_q <= '0;
               yo_q <= '0;
               c_q  <= 1'b0;
               s_q  <= 1'b0;
            end else if (en && v_src) begin
               xo_q <= a_src[HI-1:SLICE];
               yo_q <= b_src[HI-1:SLICE];
               c_q  <= sum_w[SLICE];
               s_q  <= s_src;
            end
         end
      end else begin : g_last
         logic c_msb_in;
         logic co_d;
         logic ovf_d;
         logic co_q;
         logic ovf_q;

         // Carry into the MSB cell recovered from its sum bit: s = a ^ b ^ cin.
         assign c_msb_in = a_src[SLICE-1] ^ b_src[SLICE-1] ^ sum_w[SLICE-1];
         // In subtract mode a missing carry means a borrow happened.
         assign co_d     = sum_w[SLICE] ^ s_src;
         assign ovf_d    = sum_w[SLICE] ^ c_msb_in;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               co_q  <= 1'b0;
               ovf_q <= 1'b0;
            end else if (en && v_src) begin
               co_q  <= co_d;
               ovf_q <= ovf_d;
            end
         end

         assign out_valid = vld_q;
         assign z         = r_q;
         assign c_out     = co_q;
         assign ovf       = ovf_q;
      end
   end

endmodule

// File: tb/tb_pipe_addsub.sv
module tb_pipe_addsub;

   localparam int W  = 64;
   localparam int ST = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  x;
   logic [W-1:0]  y;
   logic          c_in;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  z;
   logic          c_out;
   logic          ovf;

   // single-slice-per-stage extremes, sharing operands with the main DUT
   logic          iv1, rdy1, ov1, co1, ovf1;
   logic [W-1:0]  z1;
   logic          iv64, rdy64, ov64, co64, ovf64;
   logic [W-1:0]  z64;
   logic          aux_ordy = 1'b1;

   int            n_cmp = 0;
   int            n_err = 0;
   int            n_pop = 0;
   logic [65:0]   exp_q[$];
   logic          held = 1'b0;
   logic [65:0]   held_v;

   always #5 clk = ~clk;

   pipe_addsub #(.WIDTH(W), .STAGES(ST)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .c_in(c_in), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .z(z), .c_out(c_out), .ovf(ovf)
   );

   pipe_addsub #(.WIDTH(W), .STAGES(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1),
      .x(x), .y(y), .c_in(c_in), .sub(sub),
      .out_valid(ov1), .out_ready(aux_ordy),
      .z(z1), .c_out(co1), .ovf(ovf1)
   );

   pipe_addsub #(.WIDTH(W), .STAGES(64)) u_s64 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(rdy64),
      .x(x), .y(y), .c_in(c_in), .sub(sub),
      .out_valid(ov64), .out_ready(aux_ordy),
      .z(z64), .c_out(co64), .ovf(ovf64)
   );

   task automatic chk(input string tag, input logic [65:0] act, input logic [65:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Expected {z, c_out, ovf} from plain wide arithmetic.
   function automatic logic [65:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic ci, input logic s);
      logic [64:0]        u;
      logic signed [65:0] sa, sb, sr;
      sa = $signed({{2{a[63]}}, a});
      sb = $signed({{2{b[63]}}, b});
      if (s) begin
         u  = {1'b0, a} - {1'b0, b} - {64'd0, ci};
         sr = sa - sb - $signed({65'd0, ci});
      end else begin
         u  = {1'b0, a} + {1'b0, b} + {64'd0, ci};
         sr = sa + sb + $signed({65'd0, ci});
      end
      return {u[63:0], u[64], (sr[65:63] != 3'b000) && (sr[65:63] != 3'b111)};
   endfunction

   function automatic logic [63:0] rand64();
      logic [63:0] v;
      case ($urandom_range(0, 7))
         0: v = 64'h0;
         1: v = 64'hFFFF_FFFF_FFFF_FFFF;
         2: v = 64'h7FFF_FFFF_FFFF_FFFF;
         3: v = 64'h8000_0000_0000_0000;
         default: v = {$urandom(), $urandom()};
      endcase
      return v;
   endfunction

   // One clock cycle: drive at negedge, observe 1ns later, score handshakes.
   task automatic step(input logic iv, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic s, input logic ordy, output logic acc);
      logic [65:0] e;
      @(negedge clk);
      in_valid  = iv;
      x         = a;
      y         = b;
      c_in      = ci;
      sub       = s;
      out_ready = ordy;
      #1;
      chk("in_ready", 66'(in_ready), 66'(!out_valid || ordy));
      if (held) begin
         chk("hold_valid", 66'(out_valid), 66'(1));
         chk("hold_data", {z, c_out, ovf}, held_v);
      end
      held = 1'b0;
      if (out_valid) begin
         if (ordy) begin
            if (exp_q.size() == 0) begin
               chk("spurious", 66'(out_valid), 66'(0));
            end else begin
               e = exp_q.pop_front();
               n_pop++;
               chk("result", {z, c_out, ovf}, e);
            end
         end else begin
            held   = 1'b1;
            held_v = {z, c_out, ovf};
         end
      end
      acc = iv && in_ready;
      if (acc) exp_q.push_back(ref_model(a, b, ci, s));
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      step(1'b0, rand64(), rand64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy, acc);
   endtask

   task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic ci, input logic s,
                          input logic [63:0] ez, input logic ec, input logic eo);
      int   cnt;
      logic acc;
      step(1'b1, a, b, ci, s, 1'b1, acc);
      chk({tag, "_acc"}, 66'(acc), 66'(1));
      cnt = 0;
      while (cnt < 20) begin
         idle(1'b1);
         cnt++;
         if (out_valid) break;
      end
      chk({tag, "_lat"}, 66'(cnt), 66'(ST));
      chk({tag, "_z"}, 66'(z), 66'(ez));
      chk({tag, "_cout"}, 66'(c_out), 66'(ec));
      chk({tag, "_ovf"}, 66'(ovf), 66'(eo));
   endtask

   // Slice-boundary carry through the STAGES=1 or STAGES=64 instance.
   task automatic aux_run(input int which);
      int cnt;
      logic v;
      @(negedge clk);
      in_valid = 1'b0;
      x = 64'h0000_FFFF_FFFF_FFFF;
      y = 64'h1;
      c_in = 1'b0;
      sub = 1'b0;
      #1;
      if (which == 1) begin
         chk("s1_ready", 66'(rdy1), 66'(1));
         iv1 = 1'b1;
      end else begin
         chk("s64_ready", 66'(rdy64), 66'(1));
         iv64 = 1'b1;
      end
      @(negedge clk);
      iv1  = 1'b0;
      iv64 = 1'b0;
      x    = {$urandom(), $urandom()};
      cnt  = 1;
      #1;
      v = (which == 1) ? ov1 : ov64;
      while (!v && cnt < 200) begin
         @(negedge clk);
         #1;
         cnt++;
         v = (which == 1) ? ov1 : ov64;
      end
      if (which == 1) begin
         chk("s1_lat", 66'(cnt), 66'(1));
         chk("s1_z", 66'(z1), 66'(64'h0001_0000_0000_0000));
         chk("s1_cout", 66'(co1), 66'(0));
         chk("s1_ovf", 66'(ovf1), 66'(0));
      end else begin
         chk("s64_lat", 66'(cnt), 66'(64));
         chk("s64_z", 66'(z64), 66'(64'h0001_0000_0000_0000));
         chk("s64_cout", 66'(co64), 66'(0));
         chk("s64_ovf", 66'(ovf64), 66'(0));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   sent, stall, popped0, cnt;
      logic first, acc, ordy, iv;
      logic [63:0] ra, rb;
      logic rci, rs;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; iv1 = 1'b0; iv64 = 1'b0;
      x = '0; y = '0; c_in = 1'b0; sub = 1'b0;
      #12;
      chk("rst_valid", 66'(out_valid), 66'(0));
      chk("rst_ready", 66'(in_ready), 66'(1));
      chk("rst_data", {z, c_out, ovf}, 66'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // directed cases
      run_one("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      run_one("slice_carry", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0);
      run_one("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
      run_one("sub_5_5_b", 64'd5, 64'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      run_one("sub_9_4", 64'd9, 64'd4, 1'b0, 1'b1, 64'd5, 1'b0, 1'b0);
      run_one("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      run_one("ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
      aux_run(1);
      aux_run(64);

      // back-pressure: 10 back-to-back, 5-cycle stall after first result
      sent = 0; stall = 0; first = 1'b0; popped0 = n_pop;
      ra = rand64(); rb = rand64(); rci = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc < 200 && (sent < 10 || exp_q.size() > 0); cyc++) begin
         ordy = (stall == 0);
         iv   = (sent < 10);
         step(iv, ra, rb, rci, rs, ordy, acc);
         if (!ordy && out_valid) chk("bp_in_ready", 66'(in_ready), 66'(0));
         if (stall > 0) stall--;
         if (!first && out_valid && ordy) begin
            first = 1'b1;
            stall = 5;
         end
         if (acc) begin
            sent++;
            ra = rand64(); rb = rand64(); rci = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
         end
      end
      chk("bp_count", 66'(n_pop - popped0), 66'(10));
      chk("bp_empty", 66'(exp_q.size()), 66'(0));

      // random soak
      for (int cyc = 0; cyc < 10000; cyc++) begin
         step($urandom_range(0, 9) < 6, rand64(), rand64(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, acc);
      end
      cnt = 0;
      while (exp_q.size() > 0 && cnt < 100) begin
         idle(1'b1);
         cnt++;
      end
      chk("soak_drain", 66'(exp_q.size()), 66'(0));
      idle(1'b1);

      // reset with three transactions in flight, one of them stalled at the output
      for (int i = 0; i < 3; i++) step(1'b1, rand64(), rand64(), 1'b0, 1'($urandom_range(0, 1)), 1'b1, acc);
      idle(1'b0);
      idle(1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 66'(out_valid), 66'(0));
      chk("mid_rst_data", {z, c_out, ovf}, 66'(0));
      chk("mid_rst_ready", 66'(in_ready), 66'(1));
      exp_q.delete();
      held = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         idle(1'b1);
         chk("post_rst_quiet", 66'(out_valid), 66'(0));
      end
      run_one("post_rst", 64'd2, 64'd3, 1'b0, 1'b0, 64'd5, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor.
- Splits a WIDTH-bit operation into STAGES equal slices. Each slice is a ripple chain of full-adder cells, and a register sits between slices.
- Uses a valid/ready handshake on both sides, with full back-pressure.
- Serves as the wide arithmetic datapath primitive. It replaces single-cycle combinational ripple adders where timing needs pipelining and where a subtract mode and flags are required.

Parameters:
- WIDTH, 64, operand/result width in bits. Must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages. Range 1..WIDTH. Slice width SLICE = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block can accept a transaction this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- c_in  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: add, 1: subtract.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- z  output  WIDTH  result.
- c_out  output  1  carry-out (add) / borrow-out (sub).
- ovf  output  1  signed two's-complement overflow.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Arithmetic:
  - sub=0: {c_out,z} = x + y + c_in.
  - sub=1: z = x - y - c_in, computed as x + ~y + !c_in. c_out = NOT(internal carry out of MSB), so 1 means a borrow occurred.
- ovf = carry into MSB XOR carry out of MSB, using internal carries before borrow inversion.
- Result is mod 2^WIDTH. No saturation.
- Slicing:
  - Stage k (0..STAGES-1) sums bits [k*SLICE +: SLICE] using the carry registered by stage k-1.
  - Stage 0 uses the effective carry-in (c_in, or !c_in when subtracting).
  - Upper operand slices are skew-delayed. Completed lower result slices are de-skewed, so all of z emerges in the same cycle.
  - The sub bit travels with its transaction, so mixed add/sub back-to-back is legal.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational from out_valid/out_ready only, never from in_valid).
- Data movement:
  - When en=1, every stage advances one slot.
  - A stage's valid bit loads from the previous stage's valid; stage 0 loads in_valid.
  - When en=0, all stage registers, including valids, hold.
- Latency: a transaction accepted at edge t (in_valid && in_ready) presents out_valid=1 after edge t+STAGES-1 when there is no stall. With STAGES=1 the result is visible after edge t. Throughput is 1 per cycle.
- Bubbles are not compressed. Empty slots advance with the pipe.
- Output is stable: while out_valid && !out_ready, z, c_out and ovf hold unchanged.
- Order is strictly preserved. No transaction is dropped or duplicated under any in_valid/out_ready pattern.
- Reset:
  - When rst_n goes low, all valid bits, all data/carry registers, z, c_out and ovf clear to 0 immediately, independent of clk.
  - Transactions in flight are discarded.
  - in_ready reads 1 during reset.
  - Reset is released synchronously by the environment. The first accept is allowed on the first edge after release.
- Operand and input-qualifier values when in_valid=0 are don't-care and must not affect outputs.

Test Plan (WIDTH=64, STAGES=4, out_ready=1 unless stated):
- Add wrap: x=0xFFFF_FFFF_FFFF_FFFF, y=1, c_in=0, sub=0 → z=0, c_out=1, ovf=0; out_valid rises 3 edges after the accept edge.
- Slice-boundary carry: x=0x0000_FFFF_FFFF_FFFF, y=1 → z=0x0001_0000_0000_0000, c_out=0. Repeat with STAGES=1 and STAGES=64: same result, latency 1 / 64.
- Subtract/borrow:
  - x=5, y=7, sub=1, c_in=0 → z=0xFFFF_FFFF_FFFF_FFFE, c_out=1, ovf=0.
  - x=5, y=5, sub=1, c_in=1 → z=all ones, c_out=1.
  - x=9, y=4, sub=1 → z=5, c_out=0.
- Signed overflow:
  - x=0x7FFF_FFFF_FFFF_FFFF + y=1 → z=0x8000_0000_0000_0000, ovf=1, c_out=0.
  - x=0x8000_0000_0000_0000 - y=1 → z=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- Back-pressure: 10 back-to-back random mixed add/sub transactions; hold out_ready=0 for 5 cycles after the first result.
  - in_ready drops while stalled.
  - z holds stable.
  - All 10 results match the reference model in order, with no loss or duplicates.
  - Random out_ready/in_valid soak for 10k cycles gives the same checks.
- Reset mid-flight: 3 transactions in flight; pulse rst_n low between edges.
  - out_valid, z, c_out and ovf go 0 before the next edge.
  - No stale result appears after release.
  - The next transaction x=2, y=3 yields z=5 after the normal latency.
